// File: rtl/seg7_scan_driver.sv
// Four-digit seven-segment scan driver.
// scan_clk is a slow square wave sampled as data; each synchronised rising
// edge advances the scanned digit. All outputs are registered, active-low.

// Per-digit decode and dark decision; one instance per display position.
module seg7_digit #(
  parameter int IDX = 0,
  parameter bit BLZ = 1'b0
) (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dp_en,
  input  logic       zero_up,   // this nibble and every higher one are zero
  output logic       dark,
  output logic [6:0] seg,
  output logic       dp
);

  // Digit 0 always shows, so a value of zero still displays "0".
  assign dark = blank | (BLZ && (IDX != 0) && zero_up);
  assign dp   = ~dp_en;

  // Hex to active-low segments, bit 0 = a ... bit 6 = g.
  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

module seg7_scan_driver #(
  parameter int SYNC_STAGES         = 2,
  parameter bit BLANK_LEADING_ZEROS = 1'b0
) (
  input  logic        basys_clk,
  input  logic        rst_n,
  input  logic        scan_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int NUM_DIG = 4;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic [SYNC_STAGES-1:0]       sync_q;
  logic                         hist_q;
  logic                         step;
  logic                         upd_q;
  logic [1:0]                   idx;
  logic [NUM_DIG-1:0][3:0]      nib;
  logic [NUM_DIG:0]             zero_above;
  logic [NUM_DIG-1:0]           dig_dark;
  logic [NUM_DIG-1:0]           dig_dp;
  logic [NUM_DIG-1:0][6:0]      dig_seg;

  assign nib  = digits;
  assign step = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Synchroniser chain plus history flop for rising-edge detection.
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Scan index; reset to 3 so the first step lands on digit 0.
  // upd_q marks the cycle right after idx moves.
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 2'd3;
      upd_q <= 1'b0;
    end else begin
      upd_q <= step;
      if (step) idx <= idx + 2'd1;
    end
  end

  // Leading-zero chain: zero_above[i] is set when nibbles i..3 are all zero.
  always_comb begin
    zero_above          = '0;
    zero_above[NUM_DIG] = 1'b1;
    for (int i = NUM_DIG - 1; i >= 0; i--)
      zero_above[i] = zero_above[i+1] & (nib[i] == 4'd0);
  end

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    seg7_digit #(
      .IDX (i),
      .BLZ (BLANK_LEADING_ZEROS)
    ) u_dig (
      .nib     (nib[i]),
      .blank   (blank[i]),
      .dp_en   (dp_en[i]),
      .zero_up (zero_above[i]),
      .dark    (dig_dark[i]),
      .seg     (dig_seg[i]),
      .dp      (dig_dp[i])
    );
  end

  // Output register: loads the selected digit once per slot, so input
  // changes mid-slot wait for the next slot.
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (upd_q) begin
      if (dig_dark[idx]) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= dig_seg[idx];
        dp  <= dig_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: three driver variants share stimulus; each scan_clk
// rise pushes the expected slot image with the cycle it must appear, and a
// monitor compares every cycle against the current expected image.
module tb_seg7_scan_driver;

  logic        basys_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        scan_clk  = 1'b0;
  logic [15:0] digits    = '0;
  logic [3:0]  dp_en     = '0;
  logic [3:0]  blank     = '0;

  logic [3:0] an_o  [3];
  logic [6:0] seg_o [3];
  logic       dp_o  [3];

  always #5 basys_clk = ~basys_clk;

  // dut0: 2 sync stages; dut1: 3 sync stages; dut2: 2 stages + leading-zero blanking
  seg7_scan_driver #(.SYNC_STAGES(2), .BLANK_LEADING_ZEROS(1'b0)) u_s2 (
    .basys_clk(basys_clk), .rst_n(rst_n), .scan_clk(scan_clk), .digits(digits),
    .dp_en(dp_en), .blank(blank), .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]));
  seg7_scan_driver #(.SYNC_STAGES(3), .BLANK_LEADING_ZEROS(1'b0)) u_s3 (
    .basys_clk(basys_clk), .rst_n(rst_n), .scan_clk(scan_clk), .digits(digits),
    .dp_en(dp_en), .blank(blank), .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]));
  seg7_scan_driver #(.SYNC_STAGES(2), .BLANK_LEADING_ZEROS(1'b1)) u_blz (
    .basys_clk(basys_clk), .rst_n(rst_n), .scan_clk(scan_clk), .digits(digits),
    .dp_en(dp_en), .blank(blank), .an(an_o[2]), .seg(seg_o[2]), .dp(dp_o[2]));

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  // Segment patterns from the decode table, active-low, bit 0 = a.
  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  exp_t q0[$], q1[$], q2[$];
  exp_t cur [3];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_idx  = 3;

  always @(posedge basys_clk) cyc <= cyc + 1;

  function automatic exp_t dark_img();
    exp_t e;
    e.due = 0; e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    return e;
  endfunction

  // Reference: what digit i looks like given the current inputs.
  function automatic exp_t slot_img(int i, bit blz, int due);
    exp_t e;
    int   val;
    val = int'(digits);
    e = dark_img();
    e.due = due;
    if (!(blank[i] || (blz && i > 0 && (val >> (4 * i)) == 0))) begin
      e.an  = 4'b1111 & ~(4'(1) << i);
      e.seg = DEC[(val >> (4 * i)) & 15];
      e.dp  = !dp_en[i];
    end
    return e;
  endfunction

  task automatic chk(string name, int d, exp_t e);
    checks++;
    if ({an_o[d], seg_o[d], dp_o[d]} !== {e.an, e.seg, e.dp}) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, d, cyc, an_o[d], seg_o[d], dp_o[d], e.an, e.seg, e.dp);
    end
  endtask

  // Monitor: adopt each expected image on its due cycle, compare every cycle.
  always @(negedge basys_clk) begin
    if (q0.size() > 0 && q0[0].due == cyc) cur[0] = q0.pop_front();
    if (q1.size() > 0 && q1[0].due == cyc) cur[1] = q1.pop_front();
    if (q2.size() > 0 && q2[0].due == cyc) cur[2] = q2.pop_front();
    for (int d = 0; d < 3; d++) chk("slot", d, cur[d]);
  end

  // scan_clk goes high just after posedge cyc; E3 (E4 for 3 stages) is cyc+4 (+5).
  task automatic pulse(int hi, int lo);
    scan_clk = 1'b1;
    m_idx = (m_idx + 1) % 4;
    q0.push_back(slot_img(m_idx, 1'b0, cyc + 4));
    q1.push_back(slot_img(m_idx, 1'b0, cyc + 5));
    q2.push_back(slot_img(m_idx, 1'b1, cyc + 4));
    repeat (hi) @(negedge basys_clk);
    scan_clk = 1'b0;
    repeat (lo) @(negedge basys_clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must go dark before the next edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    scan_clk = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("async_rst", d, dark_img());
    q0.delete(); q1.delete(); q2.delete();
    for (int d = 0; d < 3; d++) cur[d] = dark_img();
    m_idx = 3;
    repeat (3) @(negedge basys_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi, lo;
    for (int d = 0; d < 3; d++) cur[d] = dark_img();

    // Reset held while scan_clk toggles, then quiet release.
    repeat (20) begin
      @(negedge basys_clk);
      scan_clk = ~scan_clk;
    end
    @(negedge basys_clk);
    scan_clk = 1'b0;
    rst_n = 1'b1;
    repeat (100) @(negedge basys_clk);

    // Scan order with period 8.
    digits = 16'h1234; blank = 4'b0000; dp_en = 4'b0000;
    repeat (5) pulse(4, 4);

    // Leading-zero blanking cases.
    digits = 16'h0070;
    repeat (4) pulse(4, 4);
    digits = 16'h0000;
    repeat (4) pulse(4, 4);

    // Manual blank and decimal points.
    digits = 16'h1234; blank = 4'b0100; dp_en = 4'b0101;
    repeat (4) pulse(4, 4);

    // Stuck low, then stuck high: display must hold.
    repeat (60) @(negedge basys_clk);
    pulse(60, 6);

    // Reset in the middle of slot 2.
    blank = 4'b0000;
    while (m_idx != 2) pulse(3, 4);
    repeat (2) @(negedge basys_clk);
    do_reset();
    repeat (10) @(negedge basys_clk);
    pulse(4, 4);

    // Randomised traffic with mid-slot input changes and occasional resets.
    repeat (150) begin
      case ($urandom_range(0, 4))
        0: digits = 16'($urandom) & 16'h000F;
        1: digits = 16'($urandom) & 16'h00FF;
        2: digits = 16'($urandom) & 16'h0FFF;
        3: digits = 16'h0000;
        default: digits = 16'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) blank = 4'($urandom);
      dp_en = 4'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge basys_clk);
      hi = $urandom_range(1, 5);
      lo = ((6 - hi) < 1 ? 1 : (6 - hi)) + $urandom_range(0, 4);
      pulse(hi, lo);
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    repeat (10) @(negedge basys_clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q0.size() + q1.size() + q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
